// File: rtl/range_stats.sv
// Streaming min/max tracker: collects samples from go through finish and
// reports range, max, min or midpoint one cycle after the last sample.
module range_stats #(
  parameter int WIDTH     = 10,
  parameter int CNT_WIDTH = 8,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic                 finish,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [1:0]           mode,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 error,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     min_q, min_d, max_q, max_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, count_q, count_d;
  logic [1:0]           mode_q, mode_d;
  logic                 ovf_q, ovf_d, err_q, err_d;

  logic [WIDTH-1:0]     min_run, max_run, stat_sel;
  logic [WIDTH:0]       min_ext, max_ext;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 cnt_sat;

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED) lt = $signed(a) < $signed(b);
    else        lt = a < b;
  endfunction

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go && !finish) state_d = S_RUN;
      S_RUN:   if (finish) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    done = 1'b0;
    busy = 1'b0;
    unique case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Running extremes include the current sample so the finish cycle counts.
  always_comb begin
    min_run  = lt(data_in, min_q) ? data_in : min_q;
    max_run  = lt(max_q, data_in) ? data_in : max_q;
    min_ext  = SIGNED ? {min_run[WIDTH-1], min_run} : {1'b0, min_run};
    max_ext  = SIGNED ? {max_run[WIDTH-1], max_run} : {1'b0, max_run};
    cnt_sat  = &cnt_q;
    cnt_next = cnt_sat ? cnt_q : cnt_q + CNT_WIDTH'(1);
    unique case (mode_q)
      2'b00:   stat_sel = max_run - min_run;
      2'b01:   stat_sel = max_run;
      2'b10:   stat_sel = min_run;
      default: stat_sel = WIDTH'((min_ext + max_ext) >> 1);
    endcase
  end

  always_comb begin
    min_d    = min_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (go && !finish) begin
          min_d  = data_in;
          max_d  = data_in;
          cnt_d  = CNT_WIDTH'(1);
          mode_d = mode;
          ovf_d  = 1'b0;
          err_d  = 1'b0;
        end else if (go || finish) begin
          err_d = 1'b1;
        end
      end
      S_RUN: begin
        min_d = min_run;
        max_d = max_run;
        cnt_d = cnt_next;
        ovf_d = ovf_q | cnt_sat;
        if (go) err_d = 1'b1;
        // Results land on the edge into DONE so they appear with the done pulse.
        if (finish) begin
          result_d = stat_sel;
          count_d  = cnt_next;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      min_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      min_q    <= min_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign result    = result_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_range_stats.sv
// Bench for range_stats: three instances (unsigned, signed, 2-bit counter)
// share one stimulus stream and are checked against an integer reference model.
module tb_range_stats;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       finish = 1'b0;
  logic [9:0] data_in = '0;
  logic [1:0] mode = '0;

  logic [9:0] res_w[3];
  logic       done_w[3], busy_w[3], ovf_w[3], err_w[3];
  logic [1:0] st_w[3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [9:0] smp[$];
  logic [9:0] exp_q[$];
  int         sgn_of[3] = '{0, 1, 0};
  int         cap_of[3] = '{255, 255, 3};

  // Values captured by the driver
  logic [9:0] o_res[3], a_res[3];
  logic       o_done[3], o_ovf[3], o_err[3], a_done[3], a_busy[3], a_err[3];
  int         o_cnt[3];
  logic       mid_err, mid_busy;

  always #5 clock = ~clock;

  range_stats #(.WIDTH(10), .CNT_WIDTH(8), .SIGNED(1'b0)) u_uns (
    .clock(clock), .reset_n(reset_n), .go(go), .finish(finish), .data_in(data_in),
    .mode(mode), .result(res_w[0]), .done(done_w[0]), .busy(busy_w[0]), .count(cnt0),
    .overflow(ovf_w[0]), .error(err_w[0]), .state_dbg(st_w[0]));

  range_stats #(.WIDTH(10), .CNT_WIDTH(8), .SIGNED(1'b1)) u_sgn (
    .clock(clock), .reset_n(reset_n), .go(go), .finish(finish), .data_in(data_in),
    .mode(mode), .result(res_w[1]), .done(done_w[1]), .busy(busy_w[1]), .count(cnt1),
    .overflow(ovf_w[1]), .error(err_w[1]), .state_dbg(st_w[1]));

  range_stats #(.WIDTH(10), .CNT_WIDTH(2), .SIGNED(1'b0)) u_sat (
    .clock(clock), .reset_n(reset_n), .go(go), .finish(finish), .data_in(data_in),
    .mode(mode), .result(res_w[2]), .done(done_w[2]), .busy(busy_w[2]), .count(cnt2),
    .overflow(ovf_w[2]), .error(err_w[2]), .state_dbg(st_w[2]));

  function automatic int cnt_of(input int k);
    if (k == 0) return int'(cnt0);
    if (k == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  function automatic int sval(input logic [9:0] v, input int sgn);
    if (sgn != 0) return int'($signed(v));
    return int'(v);
  endfunction

  function automatic logic [9:0] model_res(input int sgn, input logic [1:0] m);
    int mn, mx, v, r;
    mn = sval(smp[0], sgn);
    mx = mn;
    foreach (smp[i]) begin
      v = sval(smp[i], sgn);
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    case (m)
      2'b00:   r = mx - mn;
      2'b01:   r = mx;
      2'b10:   r = mn;
      default: r = (mn + mx) >>> 1;
    endcase
    return r[9:0];
  endfunction

  function automatic logic [9:0] pick();
    case ($urandom_range(0, 5))
      0:       return 10'h000;
      1:       return 10'h3FF;
      2:       return 10'h200;
      3:       return 10'h1FF;
      default: return 10'($urandom);
    endcase
  endfunction

  // Drives smp[] as one sequence, captures outputs on the cycle after finish
  // and one cycle later; after_in is driven on go/finish during the done cycle.
  task automatic run_seq(input logic [1:0] m, input int go_at, input logic after_in);
    int n;
    n = smp.size();
    @(negedge clock);
    go = 1'b1; finish = 1'b0; data_in = smp[0]; mode = m;
    for (int i = 1; i < n; i++) begin
      @(negedge clock);
      if (i == 1) begin
        mid_err  = err_w[0];
        mid_busy = busy_w[0];
      end
      go = (i == go_at); finish = (i == n - 1); data_in = smp[i];
      mode = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      o_res[k] = res_w[k]; o_done[k] = done_w[k]; o_ovf[k] = ovf_w[k];
      o_err[k] = err_w[k]; o_cnt[k] = cnt_of(k);
    end
    go = after_in; finish = after_in; data_in = 10'($urandom);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      a_res[k] = res_w[k]; a_done[k] = done_w[k]; a_busy[k] = busy_w[k]; a_err[k] = err_w[k];
    end
    go = 1'b0; finish = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++; if (res_w[k] !== 10'd0) begin errors++; $display("FAIL reset_result dut%0d got %0h exp 0", k, res_w[k]); end
      checks++; if (done_w[k] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d got %b exp 0", k, done_w[k]); end
      checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", k, busy_w[k]); end
      checks++; if (cnt_of(k) !== 0) begin errors++; $display("FAIL reset_count dut%0d got %0d exp 0", k, cnt_of(k)); end
      checks++; if (ovf_w[k] !== 1'b0) begin errors++; $display("FAIL reset_overflow dut%0d got %b exp 0", k, ovf_w[k]); end
      checks++; if (err_w[k] !== 1'b0) begin errors++; $display("FAIL reset_error dut%0d got %b exp 0", k, err_w[k]); end
      checks++; if (st_w[k] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d got %0d exp 0", k, st_w[k]); end
    end
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_range();
    smp = '{10'd5, 10'd900, 10'd3, 10'd77};
    run_seq(2'b00, -1, 1'b0);
    checks++; if (mid_busy !== 1'b1) begin errors++; $display("FAIL range_busy got %b exp 1", mid_busy); end
    checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL range_done got %b exp 1", o_done[0]); end
    checks++; if (o_res[0] !== 10'd897) begin errors++; $display("FAIL range_result got %0d exp 897", o_res[0]); end
    checks++; if (o_cnt[0] !== 4) begin errors++; $display("FAIL range_count got %0d exp 4", o_cnt[0]); end
    checks++; if (o_err[0] !== 1'b0) begin errors++; $display("FAIL range_error got %b exp 0", o_err[0]); end
    checks++; if (a_done[0] !== 1'b0) begin errors++; $display("FAIL range_done_pulse got %b exp 0", a_done[0]); end
    checks++; if (a_res[0] !== 10'd897) begin errors++; $display("FAIL range_hold got %0d exp 897", a_res[0]); end
  endtask

  task automatic test_signed();
    smp = '{10'h3F8, 10'd3};
    run_seq(2'b11, -1, 1'b0);
    checks++; if (o_res[1] !== 10'h3FD) begin errors++; $display("FAIL signed_mid got %0h exp 3fd", o_res[1]); end
    checks++; if (o_res[0] !== 10'h1FD) begin errors++; $display("FAIL unsigned_mid got %0h exp 1fd", o_res[0]); end
    run_seq(2'b00, -1, 1'b0);
    checks++; if (o_res[1] !== 10'd11) begin errors++; $display("FAIL signed_range got %0d exp 11", o_res[1]); end
    checks++; if (o_res[0] !== 10'd1013) begin errors++; $display("FAIL unsigned_range got %0d exp 1013", o_res[0]); end
  endtask

  task automatic test_saturation();
    smp = '{10'd10, 10'd20, 10'd700, 10'd5, 10'd30, 10'd40};
    run_seq(2'b00, -1, 1'b0);
    checks++; if (o_cnt[2] !== 3) begin errors++; $display("FAIL sat_count got %0d exp 3", o_cnt[2]); end
    checks++; if (o_ovf[2] !== 1'b1) begin errors++; $display("FAIL sat_overflow got %b exp 1", o_ovf[2]); end
    checks++; if (o_res[2] !== 10'd695) begin errors++; $display("FAIL sat_result got %0d exp 695", o_res[2]); end
    checks++; if (o_cnt[0] !== 6) begin errors++; $display("FAIL nosat_count got %0d exp 6", o_cnt[0]); end
    checks++; if (o_ovf[0] !== 1'b0) begin errors++; $display("FAIL nosat_overflow got %b exp 0", o_ovf[0]); end
  endtask

  task automatic test_idle_errors();
    @(negedge clock); go = 1'b1; finish = 1'b1; data_in = 10'd123;
    @(negedge clock); go = 1'b0; finish = 1'b0;
    checks++; if (err_w[0] !== 1'b1) begin errors++; $display("FAIL gofin_error got %b exp 1", err_w[0]); end
    checks++; if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL gofin_busy got %b exp 0", busy_w[0]); end
    @(negedge clock);
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL gofin_done got %b exp 0", done_w[0]); end
    smp = '{10'd40, 10'd60};
    run_seq(2'b01, -1, 1'b0);
    checks++; if (mid_err !== 1'b0) begin errors++; $display("FAIL go_clears_error got %b exp 0", mid_err); end
    checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL recover_done got %b exp 1", o_done[0]); end
    checks++; if (o_res[0] !== 10'd60) begin errors++; $display("FAIL recover_result got %0d exp 60", o_res[0]); end
    @(negedge clock); finish = 1'b1;
    @(negedge clock); finish = 1'b0;
    checks++; if (err_w[0] !== 1'b1) begin errors++; $display("FAIL idle_finish_error got %b exp 1", err_w[0]); end
    checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL idle_finish_done got %b exp 0", done_w[0]); end
    smp = '{10'd7, 10'd2};
    run_seq(2'b10, -1, 1'b0);
    checks++; if (mid_err !== 1'b0) begin errors++; $display("FAIL go_clears_error2 got %b exp 0", mid_err); end
    checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL recover_done2 got %b exp 1", o_done[0]); end
    checks++; if (o_res[0] !== 10'd2) begin errors++; $display("FAIL recover_result2 got %0d exp 2", o_res[0]); end
  endtask

  task automatic test_go_mid();
    smp = '{10'd100, 10'd200, 10'd1000, 10'd50, 10'd300};
    run_seq(2'b01, 2, 1'b0);
    checks++; if (o_err[0] !== 1'b1) begin errors++; $display("FAIL gomid_error got %b exp 1", o_err[0]); end
    checks++; if (o_res[0] !== 10'd1000) begin errors++; $display("FAIL gomid_result got %0d exp 1000", o_res[0]); end
    checks++; if (o_cnt[0] !== 5) begin errors++; $display("FAIL gomid_count got %0d exp 5", o_cnt[0]); end
    smp = '{10'd100, 10'd200, 10'd300};
    run_seq(2'b10, 2, 1'b0);
    checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL gofin_run_done got %b exp 1", o_done[0]); end
    checks++; if (o_err[0] !== 1'b1) begin errors++; $display("FAIL gofin_run_error got %b exp 1", o_err[0]); end
    checks++; if (o_res[0] !== 10'd100) begin errors++; $display("FAIL gofin_run_result got %0d exp 100", o_res[0]); end
    checks++; if (o_cnt[0] !== 3) begin errors++; $display("FAIL gofin_run_count got %0d exp 3", o_cnt[0]); end
  endtask

  task automatic test_reset_mid();
    @(negedge clock); go = 1'b1; data_in = 10'd500; mode = 2'b00;
    @(negedge clock); go = 1'b0; data_in = 10'd20;
    @(negedge clock); data_in = 10'd900;
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (busy_w[k] !== 1'b0) begin errors++; $display("FAIL rstmid_busy dut%0d got %b exp 0", k, busy_w[k]); end
      checks++; if (res_w[k] !== 10'd0) begin errors++; $display("FAIL rstmid_result dut%0d got %0h exp 0", k, res_w[k]); end
      checks++; if (cnt_of(k) !== 0) begin errors++; $display("FAIL rstmid_count dut%0d got %0d exp 0", k, cnt_of(k)); end
      checks++; if (err_w[k] !== 1'b0) begin errors++; $display("FAIL rstmid_error dut%0d got %b exp 0", k, err_w[k]); end
    end
    @(negedge clock); finish = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (done_w[0] !== 1'b0) begin errors++; $display("FAIL rstmid_nodone cycle%0d got %b exp 0", c, done_w[0]); end
    end
    smp = '{10'd300, 10'd100, 10'd250};
    run_seq(2'b00, -1, 1'b0);
    checks++; if (o_done[0] !== 1'b1) begin errors++; $display("FAIL rstmid_next_done got %b exp 1", o_done[0]); end
    checks++; if (o_res[0] !== 10'd200) begin errors++; $display("FAIL rstmid_next_result got %0d exp 200", o_res[0]); end
    checks++; if (o_cnt[0] !== 3) begin errors++; $display("FAIL rstmid_next_count got %0d exp 3", o_cnt[0]); end
  endtask

  task automatic test_random();
    int n, exp_cnt;
    logic [1:0] m;
    logic [9:0] exp_r;
    for (int it = 0; it < 25; it++) begin
      n = (it == 0) ? 260 : $urandom_range(2, 9);
      smp.delete();
      for (int i = 0; i < n; i++) smp.push_back(pick());
      m = 2'($urandom_range(0, 3));
      for (int k = 0; k < 3; k++) exp_q.push_back(model_res(sgn_of[k], m));
      run_seq(m, -1, 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        exp_r   = exp_q.pop_front();
        exp_cnt = (n > cap_of[k]) ? cap_of[k] : n;
        checks++; if (o_done[k] !== 1'b1) begin errors++; $display("FAIL rnd_done it%0d dut%0d got %b exp 1", it, k, o_done[k]); end
        checks++; if (o_res[k] !== exp_r) begin errors++; $display("FAIL rnd_result it%0d dut%0d mode %0d got %0h exp %0h", it, k, m, o_res[k], exp_r); end
        checks++; if (o_cnt[k] !== exp_cnt) begin errors++; $display("FAIL rnd_count it%0d dut%0d got %0d exp %0d", it, k, o_cnt[k], exp_cnt); end
        checks++; if (o_ovf[k] !== (n > cap_of[k])) begin errors++; $display("FAIL rnd_overflow it%0d dut%0d got %b exp %b", it, k, o_ovf[k], n > cap_of[k]); end
        checks++; if (o_err[k] !== 1'b0) begin errors++; $display("FAIL rnd_error it%0d dut%0d got %b exp 0", it, k, o_err[k]); end
        checks++; if (a_done[k] !== 1'b0) begin errors++; $display("FAIL rnd_pulse it%0d dut%0d got %b exp 0", it, k, a_done[k]); end
        checks++; if (a_res[k] !== exp_r) begin errors++; $display("FAIL rnd_hold it%0d dut%0d got %0h exp %0h", it, k, a_res[k], exp_r); end
        checks++; if (a_busy[k] !== 1'b0) begin errors++; $display("FAIL rnd_done_ignores_go it%0d dut%0d got %b exp 0", it, k, a_busy[k]); end
        checks++; if (a_err[k] !== 1'b0) begin errors++; $display("FAIL rnd_done_ignores_finish it%0d dut%0d got %b exp 0", it, k, a_err[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_range();
    test_signed();
    test_saturation();
    test_idle_errors();
    test_go_mid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
